// File: rtl/aes_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | aes_pkg                                                                  |
// | Shared AES block geometry, packer state encoding and PKCS#7 constants.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = 128;

    localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

    // Packer state encoding.
    typedef logic [1:0] packer_state_t;
    localparam packer_state_t ST_FILL   = 2'd0;
    localparam packer_state_t ST_HOLD   = 2'd1;
    localparam packer_state_t ST_PADBLK = 2'd2;

endpackage
`default_nettype wire

// File: rtl/aes_pad_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | aes_pad_gen                                                              |
// | Fills every byte after index last_idx: PKCS#7 value when                 |
// | AES_PKCS7_PAD_EN is defined, FILL_BYTE otherwise.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes_pad_gen
    import aes_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic [3:0]             last_idx,
    input  logic [AES_BLOCK_W-1:0] block_in,
    output logic [AES_BLOCK_W-1:0] block_out
);

    logic [7:0] w_pad;

`ifdef AES_PKCS7_PAD_EN
    // 16 - (k + 1) equals 15 - k, which fits in the low nibble.
    assign w_pad = {4'h0, 4'hF - last_idx};
`else
    assign w_pad = FILL_BYTE;
`endif

    generate
        for (genvar i = 0; i < AES_BLOCK_BYTES; i++) begin : g_byte
            assign block_out[AES_BLOCK_W-1-8*i -: 8] =
                (4'(i) > last_idx) ? w_pad : block_in[AES_BLOCK_W-1-8*i -: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_block_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | aes_block_packer                                                         |
// | Packs a valid/ready byte stream into 128-bit AES plaintext blocks.       |
// | Optional PKCS#7 padding via `define AES_PKCS7_PAD_EN.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes_block_packer
    import aes_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_len,
    output logic                   out_last
);

    packer_state_t          r_state;
    logic [3:0]             r_cnt;
    logic [AES_BLOCK_W-1:0] r_block;
    logic [4:0]             r_len;
    logic                   r_last;
`ifdef AES_PKCS7_PAD_EN
    logic                   r_pad_pend;
`endif

    logic                   w_xfer;
    logic                   w_done;
    logic [6:0]             w_base;
    logic [AES_BLOCK_W-1:0] w_merged;
    logic [AES_BLOCK_W-1:0] w_padded;

    assign w_xfer = in_valid && (r_state == ST_FILL);
    assign w_done = w_xfer && (in_last || (r_cnt == 4'hF));

    // MSB of byte cnt is bit 127 - 8*cnt, i.e. {~cnt, 3'b111}.
    assign w_base = {~r_cnt, 3'b111};

    always_comb begin
        w_merged           = r_block;
        w_merged[w_base -: 8] = in_data;
    end

    aes_pad_gen #(
        .FILL_BYTE (FILL_BYTE)
    ) u_pad_gen (
        .last_idx  (r_cnt),
        .block_in  (w_merged),
        .block_out (w_padded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_cnt      <= 4'd0;
            r_block    <= '0;
            r_len      <= 5'd0;
            r_last     <= 1'b0;
`ifdef AES_PKCS7_PAD_EN
            r_pad_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_done) begin
                        r_block <= w_padded;
                        r_cnt   <= 4'd0;
                        r_len   <= {1'b0, r_cnt} + 5'd1;
                        r_state <= ST_HOLD;
`ifdef AES_PKCS7_PAD_EN
                        // A message ending on a block boundary owes a full pad block.
                        if (in_last && (r_cnt == 4'hF)) begin
                            r_last     <= 1'b0;
                            r_pad_pend <= 1'b1;
                        end else begin
                            r_last <= in_last;
                        end
`else
                        r_last  <= in_last;
`endif
                    end else if (w_xfer) begin
                        r_block <= w_merged;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
`ifdef AES_PKCS7_PAD_EN
                        if (r_pad_pend) begin
                            r_block <= {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
                            r_len   <= 5'd0;
                            r_last  <= 1'b1;
                            r_state <= ST_PADBLK;
                        end else begin
                            r_state <= ST_FILL;
                        end
`else
                        r_state <= ST_FILL;
`endif
                    end
                end
`ifdef AES_PKCS7_PAD_EN
                ST_PADBLK: begin
                    if (out_ready) begin
                        r_pad_pend <= 1'b0;
                        r_state    <= ST_FILL;
                    end
                end
`endif
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_FILL);
`ifdef AES_PKCS7_PAD_EN
    assign out_valid = (r_state == ST_HOLD) || (r_state == ST_PADBLK);
`else
    assign out_valid = (r_state == ST_HOLD);
`endif
    assign out_block = r_block;
    assign out_len   = r_len;
    assign out_last  = r_last;

endmodule
`default_nettype wire
